// File: rtl/branch_pkg.sv
// Shared types for the branch predictor: opcode encoding, BTB entry layout
// and small opcode classification helpers.
package branch_pkg;

    localparam int BP_DATA_W      = 16;
    localparam int BP_BTB_ENTRIES = 16;
    localparam int BP_IDX_W       = $clog2(BP_BTB_ENTRIES);
    localparam int BP_TAG_W       = BP_DATA_W - BP_IDX_W - 1;

    // Opcode lives in instr[3:0]; instr[4] selects imm11 vs rA target, instr[15:5] is imm11.
    typedef enum logic [3:0] {
        OP_ADD_X  = 4'h1,
        OP_SUB_X  = 4'h2,
        OP_CMP_X  = 4'h3,
        OP_J_X    = 4'h8,
        OP_JN_X   = 4'h9,
        OP_JZ_X   = 4'hA,
        OP_CALL_X = 4'hB
    } opcode_e;

    typedef struct packed {
        logic                 valid;
        logic [BP_TAG_W-1:0]  tag;
        logic [BP_DATA_W-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    localparam int BP_ENTRY_W = $bits(btb_entry_t);

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_J_X) || (op == OP_JN_X) || (op == OP_JZ_X) || (op == OP_CALL_X);
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return (op == OP_ADD_X) || (op == OP_SUB_X) || (op == OP_CMP_X);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// decode-side update read), one synchronous write port, reset clears valid/ctr.
module btb_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = BP_BTB_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IDX_W-1:0]      i_ra_idx,
    output logic [BP_ENTRY_W-1:0] o_ra_entry,
    input  logic [IDX_W-1:0]      i_rb_idx,
    output logic [BP_ENTRY_W-1:0] o_rb_entry,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [BP_ENTRY_W-1:0] i_wdata
);

    btb_entry_t r_mem [ENTRIES];

    // Reads see the array before any write landing on this edge.
    assign o_ra_entry = r_mem[i_ra_idx];
    assign o_rb_entry = r_mem[i_rb_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
                r_mem[i].ctr   <= 2'b01;
            end
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-stage BTB prediction plus decode-stage branch resolution and redirect.
// Optional statistics counters are built only when STATS_EN is defined.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int         DATA_W      = BP_DATA_W,
    parameter int         BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter logic [1:0] CTR_INIT_U  = 2'b11,
    parameter logic [1:0] CTR_INIT_C  = 2'b10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_fetch_pc,
    output logic              o_pred_taken,
    output logic [DATA_W-1:0] o_pred_target,
    input  logic              i_dec_valid,
    input  logic              i_dec_stall,
    input  logic [15:0]       i_dec_instr,
    input  logic [DATA_W-1:0] i_dec_pc,
    input  logic              i_dec_pred_taken,
    input  logic [DATA_W-1:0] i_dec_pred_tgt,
    input  logic [DATA_W-1:0] i_reg_a,
    input  logic [15:0]       i_ex_instr,
    input  logic              i_fwd_z,
    input  logic              i_fwd_n,
    input  logic              i_z,
    input  logic              i_n,
    output logic              o_redirect,
    output logic [DATA_W-1:0] o_redirect_pc,
    output logic              o_is_call,
    output logic [31:0]       o_branch_cnt,
    output logic [31:0]       o_mispred_cnt
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        else    return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [BP_ENTRY_W-1:0] w_fe_raw, w_de_raw, w_wdata_raw;
    btb_entry_t            w_fe, w_de, w_wdata;
    logic                  w_we;

    btb_table #(.ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
        .clk        (clk),
        .reset      (reset),
        .i_ra_idx   (i_fetch_pc[IDX_W:1]),
        .o_ra_entry (w_fe_raw),
        .i_rb_idx   (i_dec_pc[IDX_W:1]),
        .o_rb_entry (w_de_raw),
        .i_we       (w_we),
        .i_widx     (i_dec_pc[IDX_W:1]),
        .i_wdata    (w_wdata_raw)
    );

    assign w_fe        = w_fe_raw;
    assign w_de        = w_de_raw;
    assign w_wdata_raw = w_wdata;

    // ---------------- fetch: prediction ----------------
    logic              w_fetch_hit;
    logic [DATA_W-1:0] w_fetch_pc2;

    assign w_fetch_pc2   = i_fetch_pc + DATA_W'(2);
    assign w_fetch_hit   = w_fe.valid && (w_fe.tag == i_fetch_pc[DATA_W-1:IDX_W+1]);
    assign o_pred_taken  = !reset && w_fetch_hit && w_fe.ctr[1];
    assign o_pred_target = o_pred_taken ? w_fe.target : w_fetch_pc2;

    // ---------------- decode: resolution ----------------
    logic [3:0]               w_op;
    logic                     w_is_br, w_resolve, w_z, w_n, w_taken_raw, w_taken, w_mispred;
    logic [DATA_W-1:0]        w_dec_pc2, w_imm_tgt, w_target;
    logic signed [DATA_W-1:0] w_offset;

    assign w_op      = i_dec_instr[3:0];
    assign w_is_br   = is_branch(w_op);
    assign w_resolve = i_dec_valid && !i_dec_stall && !reset;
    assign w_dec_pc2 = i_dec_pc + DATA_W'(2);
    assign w_offset  = {{(DATA_W-12){i_dec_instr[15]}}, i_dec_instr[15:5], 1'b0};
    assign w_imm_tgt = w_dec_pc2 + w_offset;
    assign w_target  = i_dec_instr[4] ? w_imm_tgt : i_reg_a;

    // A flag-setting op in execute this cycle overrides the architectural flags.
    assign w_z = sets_flags(i_ex_instr[3:0]) ? i_fwd_z : i_z;
    assign w_n = sets_flags(i_ex_instr[3:0]) ? i_fwd_n : i_n;

    always_comb begin
        w_taken_raw = 1'b0;
        case (w_op)
            OP_J_X, OP_CALL_X: w_taken_raw = 1'b1;
            OP_JN_X:           w_taken_raw = w_n;
            OP_JZ_X:           w_taken_raw = w_z;
            default:           w_taken_raw = 1'b0;
        endcase
    end

    assign w_taken       = w_taken_raw && !reset;
    assign w_mispred     = w_resolve && ((i_dec_pred_taken != w_taken) ||
                                         (w_taken && (i_dec_pred_tgt != w_target)));
    assign o_redirect    = w_mispred;
    assign o_redirect_pc = w_taken ? w_target : w_dec_pc2;
    assign o_is_call     = w_resolve && (w_op == OP_CALL_X);

    // ---------------- table update (written at the end of the decode cycle) ----------------
    logic w_de_hit;
    assign w_de_hit = w_de.valid && (w_de.tag == i_dec_pc[DATA_W-1:IDX_W+1]);

    always_comb begin
        w_we    = 1'b0;
        w_wdata = w_de;
        if (w_resolve) begin
            if (w_is_br) begin
                if (w_de_hit) begin
                    w_we        = 1'b1;
                    w_wdata.ctr = ctr_step(w_de.ctr, w_taken);
                    if (w_taken) w_wdata.target = w_target;
                end else if (w_taken) begin
                    w_we           = 1'b1;
                    w_wdata.valid  = 1'b1;
                    w_wdata.tag    = i_dec_pc[DATA_W-1:IDX_W+1];
                    w_wdata.target = w_target;
                    w_wdata.ctr    = ((w_op == OP_J_X) || (w_op == OP_CALL_X)) ? CTR_INIT_U : CTR_INIT_C;
                end
            end else if (w_de_hit) begin
                // Non-branch aliasing onto a live entry: drop it so it stops predicting.
                w_we          = 1'b1;
                w_wdata.valid = 1'b0;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{i_ex_instr[15:4], w_fe.ctr[0]};

`ifdef STATS_EN
    logic [31:0] r_branch_cnt, r_mispred_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            if (w_resolve && w_is_br) r_branch_cnt  <= r_branch_cnt + 32'd1;
            if (w_mispred)            r_mispred_cnt <= r_mispred_cnt + 32'd1;
        end
    end

    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;
`else
    assign o_branch_cnt  = 32'd0;
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: prediction, resolution, counters,
// stall, aliasing, wrap and reset discard; stats expectations follow STATS_EN.
module tb_branch_predict_unit;
    import branch_pkg::*;

    logic        clk, reset;
    logic [15:0] i_fetch_pc, i_dec_instr, i_dec_pc, i_dec_pred_tgt, i_reg_a, i_ex_instr;
    logic        i_dec_valid, i_dec_stall, i_dec_pred_taken, i_fwd_z, i_fwd_n, i_z, i_n;
    logic        o_pred_taken, o_redirect, o_is_call;
    logic [15:0] o_pred_target, o_redirect_pc;
    logic [31:0] o_branch_cnt, o_mispred_cnt;

    int errors = 0;
    int checks = 0;
    int exp_br = 0;
    int exp_mp = 0;
    logic [31:0] eb, em;

    localparam logic [3:0] OP_LD = 4'h4;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .i_fetch_pc(i_fetch_pc),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .i_dec_valid(i_dec_valid), .i_dec_stall(i_dec_stall), .i_dec_instr(i_dec_instr),
        .i_dec_pc(i_dec_pc), .i_dec_pred_taken(i_dec_pred_taken), .i_dec_pred_tgt(i_dec_pred_tgt),
        .i_reg_a(i_reg_a), .i_ex_instr(i_ex_instr), .i_fwd_z(i_fwd_z), .i_fwd_n(i_fwd_n),
        .i_z(i_z), .i_n(i_n), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_is_call(o_is_call), .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [15:0] mk(input logic [10:0] imm, input logic use_imm, input logic [3:0] op);
        return {imm, use_imm, op};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        i_dec_valid = 1'b0; i_dec_stall = 1'b0; i_dec_instr = 16'h0; i_dec_pc = 16'h0;
        i_dec_pred_taken = 1'b0; i_dec_pred_tgt = 16'h0;
    endtask

    task automatic dec(input logic [15:0] instr, input logic [15:0] pc, input logic pt, input logic [15:0] ptgt);
        i_dec_valid = 1'b1; i_dec_stall = 1'b0; i_dec_instr = instr; i_dec_pc = pc;
        i_dec_pred_taken = pt; i_dec_pred_tgt = ptgt;
    endtask

    task automatic test_reset;
        reset = 1'b1; i_fetch_pc = 16'h0040; i_reg_a = 16'h0200;
        i_ex_instr = {12'h0, OP_LD}; i_fwd_z = 0; i_fwd_n = 0; i_z = 0; i_n = 0;
        dec(mk(11'd0, 1'b0, OP_CALL_X), 16'h0010, 1'b0, 16'h0);
        #1;
        checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken got=%b exp=0", o_pred_taken); end
        checks++; if (o_pred_target !== 16'h0042) begin errors++; $display("FAIL rst_pred_target got=%h exp=0042", o_pred_target); end
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got=%b exp=0", o_redirect); end
        checks++; if (o_redirect_pc !== 16'h0012) begin errors++; $display("FAIL rst_redirect_pc got=%h exp=0012", o_redirect_pc); end
        checks++; if (o_is_call !== 1'b0) begin errors++; $display("FAIL rst_is_call got=%b exp=0", o_is_call); end
        tick;
        reset = 1'b0; idle;
        exp_br = 0; exp_mp = 0;
        #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0042) begin errors++; $display("FAIL post_rst_lookup got=%b/%h exp=0/0042", o_pred_taken, o_pred_target); end
        checks++; if (o_branch_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", o_branch_cnt, o_mispred_cnt); end
    endtask

    task automatic test_jump_alloc;
        i_fetch_pc = 16'h0040;
        dec(mk(11'd8, 1'b1, OP_J_X), 16'h0040, 1'b0, 16'h0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0052) begin errors++; $display("FAIL j_redirect got=%b/%h exp=1/0052", o_redirect, o_redirect_pc); end
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0042) begin errors++; $display("FAIL j_no_bypass got=%b/%h exp=0/0042", o_pred_taken, o_pred_target); end
        exp_br++; exp_mp++;
        tick;
        idle; #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 16'h0052) begin errors++; $display("FAIL j_alloc_lookup got=%b/%h exp=1/0052", o_pred_taken, o_pred_target); end
        dec(mk(11'd8, 1'b1, OP_J_X), 16'h0040, 1'b1, 16'h0052);
        #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL j_correct_pred got=%b exp=0", o_redirect); end
        exp_br++;
        tick;
    endtask

    task automatic test_flag_fwd;
        i_ex_instr = {12'h0, OP_CMP_X}; i_fwd_z = 1'b1; i_z = 1'b0;
        dec(mk(11'd4, 1'b1, OP_JZ_X), 16'h0060, 1'b0, 16'h0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h006A) begin errors++; $display("FAIL jz_fwd_taken got=%b/%h exp=1/006a", o_redirect, o_redirect_pc); end
        exp_br++; exp_mp++;
        tick;
        idle; i_fetch_pc = 16'h0060; #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 16'h006A) begin errors++; $display("FAIL jz_alloc_lookup got=%b/%h exp=1/006a", o_pred_taken, o_pred_target); end
        i_fetch_pc = 16'h0040; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0042) begin errors++; $display("FAIL evicted_lookup got=%b/%h exp=0/0042", o_pred_taken, o_pred_target); end
        i_ex_instr = {12'h0, OP_LD};
        dec(mk(11'd4, 1'b1, OP_JZ_X), 16'h0060, 1'b1, 16'h006A);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0062) begin errors++; $display("FAIL jz_arch_not_taken got=%b/%h exp=1/0062", o_redirect, o_redirect_pc); end
        exp_br++; exp_mp++;
        tick;
        idle; i_fetch_pc = 16'h0060; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0062) begin errors++; $display("FAIL jz_ctr_dec_lookup got=%b/%h exp=0/0062", o_pred_taken, o_pred_target); end
        i_fwd_z = 1'b0;
    endtask

    task automatic test_ctr_decay;
        logic [15:0] jn;
        logic        exp_rd [6];
        logic [15:0] exp_pc [6];
        logic        nflag  [6];
        logic        pt     [6];
        jn = mk(11'd0, 1'b0, OP_JN_X);
        i_reg_a = 16'h1234; i_ex_instr = {12'h0, OP_LD};
        // alloc(10) -> hit taken(11) -> not taken(10) -> not taken(01) -> not taken(00) -> taken(01)
        nflag  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pt     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rd = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_pc = '{16'h1234, 16'h1234, 16'h0026, 16'h0026, 16'h0026, 16'h1234};
        for (int k = 0; k < 6; k++) begin
            i_n = nflag[k];
            dec(jn, 16'h0024, pt[k], 16'h1234);
            #1;
            checks++;
            if (o_redirect !== exp_rd[k] || (exp_rd[k] && o_redirect_pc !== exp_pc[k])) begin
                errors++; $display("FAIL jn_step%0d got=%b/%h exp=%b/%h", k, o_redirect, o_redirect_pc, exp_rd[k], exp_pc[k]);
            end
            exp_br++; if (exp_rd[k]) exp_mp++;
            tick;
            idle; i_fetch_pc = 16'h0024; #1;
            if (k == 2) begin
                checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 16'h1234) begin errors++; $display("FAIL jn_ctr10_lookup got=%b/%h exp=1/1234", o_pred_taken, o_pred_target); end
            end
            if (k == 3 || k == 5) begin
                checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0026) begin errors++; $display("FAIL jn_weak_lookup%0d got=%b/%h exp=0/0026", k, o_pred_taken, o_pred_target); end
            end
        end
        i_n = 1'b0;
    endtask

    task automatic test_stall;
        i_ex_instr = {12'h0, OP_ADD_X}; i_fwd_z = 1'b1; i_z = 1'b0;
        dec(mk(11'h7FE, 1'b1, OP_JZ_X), 16'h0046, 1'b0, 16'h0);
        i_dec_stall = 1'b1;
        #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect got=%b exp=0", o_redirect); end
        tick;
        i_fetch_pc = 16'h0046; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0048) begin errors++; $display("FAIL stall_table got=%b/%h exp=0/0048", o_pred_taken, o_pred_target); end
        tick;
        i_dec_stall = 1'b0; #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0044) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/0044", o_redirect, o_redirect_pc); end
        exp_br++; exp_mp++;
        tick;
        idle; #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL stall_once got=%b exp=0", o_redirect); end
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 16'h0044) begin errors++; $display("FAIL stall_alloc got=%b/%h exp=1/0044", o_pred_taken, o_pred_target); end
        i_ex_instr = {12'h0, OP_LD}; i_fwd_z = 1'b0;
    endtask

    task automatic test_wrap;
        dec(mk(11'd1, 1'b1, OP_J_X), 16'hFFFE, 1'b0, 16'h0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0002) begin errors++; $display("FAIL wrap_target got=%b/%h exp=1/0002", o_redirect, o_redirect_pc); end
        exp_br++; exp_mp++;
        tick;
        idle;
    endtask

    task automatic test_alias;
        i_reg_a = 16'h0300;
        dec(mk(11'd0, 1'b0, OP_CALL_X), 16'h0080, 1'b0, 16'h0);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0300) begin errors++; $display("FAIL call_redirect got=%b/%h exp=1/0300", o_redirect, o_redirect_pc); end
        checks++; if (o_is_call !== 1'b1) begin errors++; $display("FAIL call_is_call got=%b exp=1", o_is_call); end
        exp_br++; exp_mp++;
        tick;
        idle; i_fetch_pc = 16'h0080; #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_target !== 16'h0300) begin errors++; $display("FAIL call_lookup got=%b/%h exp=1/0300", o_pred_taken, o_pred_target); end
        dec(mk(11'd0, 1'b0, OP_ADD_X), 16'h0080, 1'b1, 16'h0300);
        #1;
        checks++; if (o_redirect !== 1'b1 || o_redirect_pc !== 16'h0082 || o_is_call !== 1'b0) begin errors++; $display("FAIL alias_redirect got=%b/%h/%b exp=1/0082/0", o_redirect, o_redirect_pc, o_is_call); end
        exp_mp++;
        tick;
        idle; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0082) begin errors++; $display("FAIL alias_invalidated got=%b/%h exp=0/0082", o_pred_taken, o_pred_target); end
`ifdef STATS_EN
        eb = 32'(exp_br); em = 32'(exp_mp);
`else
        eb = 32'd0; em = 32'd0;
`endif
        checks++; if (o_branch_cnt !== eb) begin errors++; $display("FAIL branch_cnt got=%0d exp=%0d", o_branch_cnt, eb); end
        checks++; if (o_mispred_cnt !== em) begin errors++; $display("FAIL mispred_cnt got=%0d exp=%0d", o_mispred_cnt, em); end
    endtask

    task automatic test_reset_discard;
        reset = 1'b1;
        dec(mk(11'd3, 1'b1, OP_J_X), 16'h00A0, 1'b0, 16'h0);
        #1;
        checks++; if (o_redirect !== 1'b0) begin errors++; $display("FAIL rst_mid_redirect got=%b exp=0", o_redirect); end
        tick;
        reset = 1'b0; idle; exp_br = 0; exp_mp = 0;
        i_fetch_pc = 16'h00A0; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h00A2) begin errors++; $display("FAIL rst_discard got=%b/%h exp=0/00a2", o_pred_taken, o_pred_target); end
        i_fetch_pc = 16'h0046; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_target !== 16'h0048) begin errors++; $display("FAIL rst_clear got=%b/%h exp=0/0048", o_pred_taken, o_pred_target); end
        checks++; if (o_branch_cnt !== 32'd0 || o_mispred_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", o_branch_cnt, o_mispred_cnt); end
    endtask

    initial begin
        test_reset;
        test_jump_alloc;
        test_flag_fwd;
        test_ctr_decay;
        test_stall;
        test_wrap;
        test_alias;
        test_reset_discard;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
